// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one Avalon-style memory slave between the CPU instruction-fetch
//   port (i_*) and data port (d_*). One transaction is latched at a time,
//   driven onto m_*, and held until the memory drops m_waitrequest. If the
//   memory never answers, a watchdog aborts the transfer. The granted port
//   then gets ERR_DATA, and bus_error pulses for one cycle.
//
//   Parameters
//     TIMEOUT_CYCLES  WAIT cycles allowed before an abort (2..65535)
//     ERR_DATA        readdata returned on an aborted transfer
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     i_address/i_read              fetch request (read only)
//     i_readdata/i_waitrequest      fetch response / stall
//     d_address/d_read/d_write      data request
//     d_writedata/d_byteenable      store data and byte lanes
//     d_readdata/d_waitrequest      load response / stall
//     m_address/m_read/m_write      memory command (registered)
//     m_writedata/m_byteenable      memory write data and lanes (registered)
//     m_readdata/m_waitrequest      memory response
//     bus_error                     one-cycle pulse on a timeout abort
//
//   Build option
//     ARB_ROUND_ROBIN_EN  when defined, contention alternates between the
//                         two ports. When undefined, the data port always
//                         wins.

module mem_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic [31:0] i_readdata,
  output logic        i_waitrequest,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        grant_d;
  logic [15:0] timeout_cnt;
  logic        i_req;
  logic        d_req;
  logic        pick_d;
  logic        complete;
  logic        abort;
  logic        i_done;
  logic        d_done;
  logic [31:0] resp_data;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which port was granted last. It resets to "instruction", so
  // the first contention after reset goes to the data port.
  logic last_grant_d;

  assign pick_d = d_req & (~i_req | ~last_grant_d);
`else
  assign pick_d = d_req;
`endif

  // State register. Reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and per-port responses. A port's stall is released
  // only in the single cycle its own transfer finishes. A normal completion
  // takes precedence over the watchdog in the same cycle.
  always_comb begin
    state_next    = state;
    complete      = 1'b0;
    abort         = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    resp_data     = m_readdata;
    i_readdata    = 32'h0;
    d_readdata    = 32'h0;
    i_waitrequest = 1'b0;
    d_waitrequest = 1'b0;
    bus_error     = 1'b0;
    case (state)
      ST_IDLE:  if (i_req | d_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!m_waitrequest) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    i_done        = (complete | abort) & ~grant_d;
    d_done        = (complete | abort) & grant_d;
    if (abort) resp_data = ERR_DATA;
    if (i_done) i_readdata = resp_data;
    if (d_done) d_readdata = resp_data;
    i_waitrequest = i_req & ~i_done;
    d_waitrequest = d_req & ~d_done;
    bus_error     = abort;
  end

  // Command latch and watchdog. The command is captured once in IDLE, so
  // any later change on the requester's inputs has no effect on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_d      <= 1'b0;
      m_address    <= 32'h0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= 32'h0;
      m_byteenable <= 4'h0;
      timeout_cnt  <= 16'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req | d_req) begin
            grant_d      <= pick_d;
            m_read       <= pick_d ? d_read : 1'b1;
            m_write      <= pick_d & d_write;
            m_address    <= pick_d ? d_address : i_address;
            m_writedata  <= pick_d ? d_writedata : 32'h0;
            m_byteenable <= pick_d ? d_byteenable : 4'b1111;
            timeout_cnt  <= 16'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= pick_d;
`endif
          end
        end
        ST_WAIT: begin
          if (complete | abort) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
          end else if (timeout_cnt != 16'hFFFF) begin
            timeout_cnt <= timeout_cnt + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter. A behavioural memory stalls
//   each command for a chosen number of WAIT cycles and returns an
//   address-derived word. The expected timeline of every session comes from
//   the latency/arbitration rules using plain arithmetic.

module tb_mem_bus_arbiter;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_address = 32'h0;
  logic        i_read = 1'b0;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  logic [31:0] d_address = 32'h0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = 32'h0;
  logic [3:0]  d_byteenable = 4'h0;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic        bus_error;

  int check_count = 0;
  int fail_count  = 0;
  int mem_latency = 0;
  int cmd_cycles;
  bit model_last_d = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_read(i_read),
    .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .bus_error(bus_error)
  );

  // Memory contents as a function of address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24020005;
    return {a[15:0], a[31:16]} ^ 32'h3C1A8E47;
  endfunction

  // Memory stalls the k-th cycle of a command while k <= mem_latency
  // (k = 0 is the ISSUE cycle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cmd_cycles <= 0;
    else if (m_read | m_write) cmd_cycles <= cmd_cycles + 1;
    else                       cmd_cycles <= 0;
  end
  assign m_waitrequest = (cmd_cycles <= mem_latency);
  assign m_readdata    = memWord(m_address);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One session: either port alone, or both at once. Called at a negedge
  // while the arbiter is idle. Each port drops its request in the cycle
  // its own transfer finishes.
  task automatic applyStimulus(input bit use_i, input bit use_d, input bit d_wr,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dbe,
                               input int lat);
    bit first_d, two, ab, i_act, d_act, i_fin, d_fin;
    bit is_d[2];
    int s[2];
    int dn[2];
    int dur, last, k;
    logic [31:0] rd_val;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = use_d && (!use_i || !model_last_d);
`else
    first_d = use_d;
`endif
    two  = use_i && use_d;
    ab   = (lat >= T);
    dur  = 1 + ((lat + 1 < T) ? lat + 1 : T);
    is_d[0] = first_d; is_d[1] = !first_d;
    s[0] = 0;          dn[0] = dur;
    s[1] = dur + 1;    dn[1] = s[1] + dur;
    last = two ? dn[1] : dn[0];
    model_last_d = two ? !first_d : first_d;
    mem_latency  = lat;
    i_read = use_i; i_address = ia;
    d_read = use_d && !d_wr; d_write = use_d && d_wr;
    d_address = da; d_writedata = dwd; d_byteenable = dbe;
    i_act = use_i; d_act = use_d;
    for (int c = 0; c <= last + 1; c++) begin
      #1;
      k = -1;
      for (int t = 0; t < (two ? 2 : 1); t++)
        if (c > s[t] && c <= dn[t]) k = t;
      i_fin = 1'b0; d_fin = 1'b0;
      if (k >= 0 && c == dn[k]) begin
        if (is_d[k]) d_fin = 1'b1;
        else         i_fin = 1'b1;
      end
      checkOutput("i_waitrequest", i_waitrequest, i_act && !i_fin);
      checkOutput("d_waitrequest", d_waitrequest, d_act && !d_fin);
      rd_val = ab ? ERR : memWord(ia);
      checkOutput("i_readdata", i_readdata, i_fin ? rd_val : 32'h0);
      rd_val = ab ? ERR : memWord(da);
      checkOutput("d_readdata", d_readdata, d_fin ? rd_val : 32'h0);
      checkOutput("bus_error", bus_error, ab && (i_fin || d_fin));
      if (k >= 0 && is_d[k]) begin
        checkOutput("m_read_d", m_read, !d_wr);
        checkOutput("m_write_d", m_write, d_wr);
        checkOutput("m_address_d", m_address, da);
        checkOutput("m_byteenable_d", m_byteenable, dbe);
        if (d_wr) checkOutput("m_writedata", m_writedata, dwd);
      end else if (k >= 0) begin
        checkOutput("m_read_i", m_read, 1);
        checkOutput("m_write_i", m_write, 0);
        checkOutput("m_address_i", m_address, ia);
        checkOutput("m_byteenable_i", m_byteenable, 4'b1111);
      end else begin
        checkOutput("m_read_idle", m_read, 0);
        checkOutput("m_write_idle", m_write, 0);
      end
      if (i_fin) begin i_read = 1'b0; i_act = 1'b0; end
      if (d_fin) begin d_read = 1'b0; d_write = 1'b0; d_act = 1'b0; end
      @(negedge clk);
    end
  endtask

  // Both ports held high for n back-to-back zero-latency transactions
  task automatic contention(input int n);
    bit exp_d;
    logic [31:0] ia, da;
    ia = $urandom & 32'hFFFFFFFC;
    da = $urandom & 32'hFFFFFFFC;
    mem_latency = 0;
    i_read = 1'b1; i_address = ia;
    d_read = 1'b1; d_write = 1'b0; d_address = da; d_byteenable = 4'hF;
    for (int k = 0; k < n; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = !model_last_d;
`else
      exp_d = 1'b1;
`endif
      model_last_d = exp_d;
      #1;
      checkOutput("cont_idle_i_wait", i_waitrequest, 1);
      checkOutput("cont_idle_m_read", m_read, 0);
      @(negedge clk); #1;
      checkOutput("cont_grant_addr", m_address, exp_d ? da : ia);
      checkOutput("cont_issue_i_wait", i_waitrequest, 1);
      @(negedge clk); #1;
      checkOutput("cont_done_i_wait", i_waitrequest, exp_d);
      checkOutput("cont_done_d_wait", d_waitrequest, !exp_d);
      checkOutput("cont_done_rdata", exp_d ? d_readdata : i_readdata,
                  memWord(exp_d ? da : ia));
      @(negedge clk);
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  initial begin
    logic [1:0] sel;
    int lat;

    $display("[TB] mem_bus_arbiter bench start");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_m_read", m_read, 0);
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_m_address", m_address, 0);
    checkOutput("rst_m_writedata", m_writedata, 0);
    checkOutput("rst_m_byteenable", m_byteenable, 0);
    checkOutput("rst_bus_error", bus_error, 0);
    checkOutput("rst_i_wait_idle", i_waitrequest, 0);
    i_read = 1'b1; d_write = 1'b1; #1;
    checkOutput("rst_i_wait_req", i_waitrequest, 1);
    checkOutput("rst_d_wait_req", d_waitrequest, 1);
    i_read = 1'b0; d_write = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_last_d = 1'b0;
    @(negedge clk);

    $display("[TB] directed: fetch, store, timeout, boundary");
    applyStimulus(1, 0, 0, 32'hBFC00000, 32'h0, 32'h0, 4'h0, 0);
    applyStimulus(0, 1, 1, 32'h0, 32'h00000010, 32'h12345678, 4'b0011, 0);
    applyStimulus(0, 1, 0, 32'h0, 32'h00000040, 32'h0, 4'hF, 1000);
    applyStimulus(0, 1, 1, 32'h0, 32'h00000080, 32'hCAFEF00D, 4'b1100, T - 1);

    $display("[TB] contention");
    contention(4);

    $display("[TB] reset mid-WAIT");
    mem_latency = 5;
    i_read = 1'b1; i_address = 32'hBFC00000;
    @(negedge clk); @(negedge clk); #1;
    checkOutput("pre_rst_m_read", m_read, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_m_read", m_read, 0);
    checkOutput("async_rst_m_address", m_address, 0);
    checkOutput("async_rst_i_wait", i_waitrequest, 1);
    @(negedge clk) rst_n = 1'b1;
    model_last_d = 1'b0;
    applyStimulus(1, 0, 0, 32'hBFC00000, 32'h0, 32'h0, 4'h0, 0);

    $display("[TB] random sessions");
    for (int n = 0; n < 40; n++) begin
      sel = 2'($urandom_range(1, 3));
      lat = ($urandom_range(0, 5) == 0) ? $urandom_range(T, T + 3)
                                        : $urandom_range(0, 4);
      applyStimulus(sel[0], sel[1], 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter sharing the single Avalon-style memory slave between the CPU's instruction-fetch port and data port. It sits between the MIPS core and the RAM model. It registers one transaction at a time, drives it onto the memory bus, and waits for completion. It stalls the losing requester via its own waitrequest. A watchdog aborts transfers the memory never completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT before abort; legal range 2..65535.
- ERR_DATA, 32'hDEADBEEF: readdata returned on an aborted read.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_address  in  32  instruction fetch address.
- i_read  in  1  instruction fetch request; read-only port.
- i_readdata  out  32  fetch data; valid when i_read=1 and i_waitrequest=0.
- i_waitrequest  out  1  instruction port stall.
- d_address  in  32  data address.
- d_read, d_write  in  1 each  data request; never both high.
- d_writedata  in  32  store data.
- d_byteenable  in  4  store/load byte lanes.
- d_readdata  out  32  load data; valid when d_read=1 and d_waitrequest=0.
- d_waitrequest  out  1  data port stall.
- m_address  out  32  to memory.
- m_read, m_write  out  1 each  to memory.
- m_writedata  out  32  to memory.
- m_byteenable  out  4  to memory.
- m_readdata  in  32  from memory.
- m_waitrequest  in  1  from memory.
- bus_error  out  1  one-cycle pulse on timeout abort.

## Operation
- State machine: IDLE, ISSUE, WAIT.
- IDLE: m_read=m_write=0. If any request is present, choose a winner and latch its address, writedata, byteenable (instruction port forces 4'b1111) and direction into m_* registers. Record the grant and go to ISSUE.
- ISSUE: m_* command asserted. m_waitrequest is ignored. Go to WAIT unconditionally.
- WAIT: command held.
  - m_waitrequest=0: the transfer completes. The granted port's waitrequest is 0 this cycle and its readdata equals m_readdata. Next state is IDLE.
  - Otherwise the timeout counter increments.
  - Counter reaching TIMEOUT_CYCLES-1: abort. The granted port's waitrequest is 0, its readdata=ERR_DATA, bus_error=1, next state IDLE.
- Port waitrequest is 1 whenever that port requests and is not completing this cycle. It is 0 when the port is idle.
- Arbitration (see Configuration): with both ports requesting in IDLE and fixed priority, data wins.
- The requester holds its address, data and command stable while its waitrequest=1. Changes mid-transfer are ignored because the command is latched.
- A request dropped mid-transfer does not cancel it. The transfer runs to completion and its result is discarded.
- Readdata outputs are 0 when the port is not completing.

## Timing
- Reset (async assert): state=IDLE. m_read=m_write=0, m_address=m_writedata=0, m_byteenable=0, bus_error=0, timeout counter=0, last-grant=instruction. i_/d_waitrequest follow their rule (1 if requesting). Reset mid-transfer abandons the transfer immediately.
- Minimum latency: request seen in IDLE at edge 0, ISSUE after edge 1, WAIT after edge 2, completion in the WAIT cycle, back to IDLE at edge 3. This is 3 cycles request-to-IDLE.
- One IDLE cycle always separates transactions. The next grant is decided in that IDLE cycle.
- The timeout counter clears on entry to ISSUE. It is 16 bits and saturates; it never wraps.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the port not recorded as last-grant wins. The first contention after reset goes to data.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data always beats instruction. The last-grant register is not built.

## Test plan
- Single fetch: i_read, i_address=32'hBFC00000, memory returns 32'h24020005 with m_waitrequest=0 in WAIT -> i_waitrequest low exactly one cycle with i_readdata=32'h24020005, 3 cycles total.
- Store: d_write, d_address=32'h00000010, d_writedata=32'h12345678, d_byteenable=4'b0011 -> m_write with the same address, data and byteenable for ISSUE+WAIT; i_read idle throughout.
- Contention, macro undefined: i_read and d_read asserted together, held for three transactions -> data granted every time; instruction starved while d_read stays high.
- Contention, ARB_ROUND_ROBIN_EN defined: both held high -> grants alternate D, I, D, I.
- Timeout: TIMEOUT_CYCLES=8, m_waitrequest stuck 1 on d_read -> abort in the 8th WAIT cycle, d_readdata=32'hDEADBEEF, bus_error pulses once, state IDLE.
- Reset mid-WAIT: rst_n low during a fetch -> m_read drops with no clock edge; after release the fetch restarts from IDLE with 3-cycle latency.
